pulse_xfer_sched: RTL and testbench

PULSE_XFER_SCHED -- requirements
Module: pulse_xfer_sched

---
 rtl/pulse_xfer_sched_pkg.sv | 22 ++
 rtl/pulse_xfer_sched_rr_arbiter.sv | 39 +++
 rtl/pulse_xfer_sched.sv | 119 +++++++++++
 tb/tb_pulse_xfer_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_xfer_sched_pkg.sv
// Shared types and default sizing for the pulse transfer scheduler.
package pulse_xfer_sched_pkg;

    // Scheduler FSM states: wait for work, fire the pulse, wait for the
    // synchronizer round trip, then hold off before the next pulse.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_GAP_CYCLES     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    // Index width that stays legal even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_xfer_sched_rr_arbiter.sv
// Combinational round-robin picker over the pending flags.
module rr_arbiter
    import pulse_xfer_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [ID_W-1:0]    last_idx,
    input  logic               last_valid,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_idx
);

    int base;
    int idx;

    // Search starts one past the last grant (or at 0 before any grant) and wraps.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        base        = last_valid ? (int'(last_idx) + 1) : 0;
        if (base >= NUM_REQ) begin
            base = 0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && (|(pend & (NUM_REQ'(1) << idx)))) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pulse_xfer_sched.sv
// Shares one fast-to-slow pulse synchronizer between several requesters.
module pulse_xfer_sched
    import pulse_xfer_sched_pkg::*;
#(
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W           = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    output logic               pulse_out,
    output logic [ID_W-1:0]    pulse_id,
    output logic               busy,
    output logic [NUM_REQ-1:0] pend,
    output logic [NUM_REQ-1:0] drop,
    output logic               timeout_err
);

    // One down-counter serves both the ack timeout and the post-transfer gap.
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    last_idx;
    logic               last_valid;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] clear_mask;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .pend        (pend),
        .last_idx    (last_idx),
        .last_valid  (last_valid),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Pend bit consumed by a grant this cycle; a coincident req still re-sets it.
    always_comb begin
        clear_mask = '0;
        if (state == IDLE && grant_valid) begin
            clear_mask = NUM_REQ'(1) << grant_idx;
        end
    end

    // Pend/drop bookkeeping plus the transfer FSM, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pend        <= '0;
            drop        <= '0;
            pulse_out   <= 1'b0;
            pulse_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            last_idx    <= '0;
            last_valid  <= 1'b0;
        end else begin
            drop        <= req & pend & ~clear_mask;
            pend        <= (pend & ~clear_mask) | req;
            pulse_out   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state      <= SEND;
                        pulse_out  <= 1'b1;
                        pulse_id   <= grant_idx;
                        last_idx   <= grant_idx;
                        last_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    state <= WAIT_ACK;
                    cnt   <= TIMEOUT_LOAD;
                end
                WAIT_ACK: begin
                    if (ack || cnt == '0) begin
                        timeout_err <= ~ack;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Directed bench for pulse_xfer_sched: a cycle table plus multi-cycle corner sequences.
module tb_pulse_xfer_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       pulse_out;
    logic [1:0] pulse_id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] drop;
    logic       timeout_err;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic       po;
        logic [1:0] id;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] drop;
        logic       to;
    } vec_t;

    vec_t vq[$];

    pulse_xfer_sched #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (3),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .pulse_out   (pulse_out),
        .pulse_id    (pulse_id),
        .busy        (busy),
        .pend        (pend),
        .drop        (drop),
        .timeout_err (timeout_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic a);
        @(negedge clk);
        rst = r;
        req = q;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] q, input logic a,
                          input logic po, input logic [1:0] id, input logic b,
                          input logic [3:0] p, input logic [3:0] d, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.ack = a;
        v.po = po; v.id = id; v.busy = b; v.pend = p; v.drop = d; v.to = t;
        vq.push_back(v);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int to_step;
        int to_count;
        int n_pulses;
        int ids[4];
        int times[4];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = '0;
        ack = 1'b0;

        // Single event, drop during busy, ack ignored in GAP, set-wins re-queue.
        //     rst req     ack po id    busy pend     drop     to
        addVec(1, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0001, 0, 0, 2'd0, 0, 4'b0001, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 1, 2'd0, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd0, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0100, 0, 0, 2'd0, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0100, 0, 0, 2'd0, 1, 4'b0100, 4'b0100, 0);
        addVec(0, 4'b0000, 0, 0, 2'd0, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 1, 0, 2'd0, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 1, 0, 2'd0, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd0, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd0, 0, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0100, 0, 1, 2'd2, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 1, 0, 2'd2, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 0, 4'b0100, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 1, 2'd2, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 1, 0, 2'd2, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 1, 4'b0000, 4'b0000, 0);
        addVec(0, 4'b0000, 0, 0, 2'd2, 0, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].rst, vq[i].req, vq[i].ack);
            checkOutput($sformatf("row%0d pulse_out", i), pulse_out, vq[i].po);
            checkOutput($sformatf("row%0d pulse_id", i), pulse_id, vq[i].id);
            checkOutput($sformatf("row%0d busy", i), busy, vq[i].busy);
            checkOutput($sformatf("row%0d pend", i), pend, vq[i].pend);
            checkOutput($sformatf("row%0d drop", i), drop, vq[i].drop);
            checkOutput($sformatf("row%0d timeout_err", i), timeout_err, vq[i].to);
        end

        // Timeout: no ack at all, expect timeout_err 16 cycles after pulse_out.
        applyStimulus(0, 4'b0010, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("timeout pulse_out", pulse_out, 1);
        checkOutput("timeout pulse_id", pulse_id, 1);
        to_step = -1;
        to_count = 0;
        for (int s = 1; s <= 20; s++) begin
            applyStimulus(0, 4'b0000, 0);
            if (timeout_err) begin
                to_count++;
                if (to_step < 0) to_step = s;
            end
            if (s == 18) checkOutput("timeout gap busy", busy, 1);
            if (s == 19) checkOutput("timeout idle busy", busy, 0);
        end
        checkOutput("timeout step", to_step, 16);
        checkOutput("timeout count", to_count, 1);

        // Ack arriving on the expiry cycle counts as success.
        applyStimulus(0, 4'b0001, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("late-ack pulse_out", pulse_out, 1);
        for (int s = 1; s <= 15; s++) begin
            applyStimulus(0, 4'b0000, 0);
        end
        applyStimulus(0, 4'b0000, 1);
        checkOutput("late-ack timeout_err", timeout_err, 0);
        checkOutput("late-ack busy", busy, 1);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 4'b0000, 0);
        end
        checkOutput("late-ack idle busy", busy, 0);

        // Fairness after reset: all four channels at once, ack always present.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b1111, 1);
        n_pulses = 0;
        for (int c = 0; c < 60; c++) begin
            applyStimulus(0, 4'b0000, 1);
            if (pulse_out) begin
                if (n_pulses < 4) begin
                    ids[n_pulses] = int'(pulse_id);
                    times[n_pulses] = c;
                end
                n_pulses++;
            end
        end
        checkOutput("fair pulse count", n_pulses, 4);
        for (int k = 0; k < 4 && k < n_pulses; k++) begin
            checkOutput($sformatf("fair id%0d", k), ids[k], k);
            if (k > 0) begin
                checkOutput($sformatf("fair spacing%0d ok", k), (times[k] - times[k-1]) >= 5, 1);
            end
        end
        checkOutput("fair pend empty", pend, 0);

        // Reset in WAIT_ACK with channels 1 and 3 pending.
        applyStimulus(0, 4'b1000, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("rstmid pulse_id", pulse_id, 3);
        applyStimulus(0, 4'b1010, 0);
        checkOutput("rstmid pend before", pend, 4'b1010);
        applyStimulus(1, 4'b0100, 0);
        checkOutput("rstmid pulse_out", pulse_out, 0);
        checkOutput("rstmid pulse_id", pulse_id, 0);
        checkOutput("rstmid busy", busy, 0);
        checkOutput("rstmid pend", pend, 0);
        checkOutput("rstmid drop", drop, 0);
        checkOutput("rstmid timeout_err", timeout_err, 0);
        n_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 4'b0000, 0);
            if (pulse_out) n_pulses++;
        end
        checkOutput("rstmid no pulse", n_pulses, 0);
        checkOutput("rstmid busy after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
